// File: rtl/settings_menu_ctrl.sv
// Pre-game settings menu: button presses edit sound/theme/hearts,
// START hands control to the game, game_over returns to the menu.
module settings_menu_ctrl #(
    parameter int HEARTS_MIN     = 1,
    parameter int HEARTS_MAX     = 6,
    parameter int HEARTS_DEFAULT = 3,
    parameter int BLINK_FRAMES   = 15
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_enter,
    input  logic       startOfFrame,
    input  logic       game_over,
    output logic       sound_choice,
    output logic       theme_choice,
    output logic [2:0] hearts_choice,
    output logic       game_started,
    output logic       start_pulse,
    output logic       menu_active,
    output logic [1:0] cursor_row,
    output logic       cursor_blink
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [2:0] H_MIN = 3'(HEARTS_MIN);
    localparam logic [2:0] H_MAX = 3'(HEARTS_MAX);
    localparam logic [2:0] H_DEF = 3'(HEARTS_DEFAULT);
    localparam logic [CW-1:0] B_LAST = CW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {MENU, START_WAIT, GAME, OVER_WAIT} state_t;

    state_t state, state_n;
    logic [4:0] btn, prev, press;
    logic [CW-1:0] cnt, cnt_n;
    logic sound_n, theme_n, gs_n, sp_n, blink_n;
    logic [2:0] hearts_n;
    logic [1:0] cursor_n;

    // Bit order: enter, up, down, left, right
    assign btn   = {btn_enter, btn_up, btn_down, btn_left, btn_right};
    assign press = btn & ~prev;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= MENU;
            prev          <= '1;
            sound_choice  <= 1'b0;
            theme_choice  <= 1'b0;
            hearts_choice <= H_DEF;
            game_started  <= 1'b0;
            start_pulse   <= 1'b0;
            menu_active   <= 1'b1;
            cursor_row    <= 2'd0;
            cursor_blink  <= 1'b1;
            cnt           <= '0;
        end else begin
            state         <= state_n;
            prev          <= btn;
            sound_choice  <= sound_n;
            theme_choice  <= theme_n;
            hearts_choice <= hearts_n;
            game_started  <= gs_n;
            start_pulse   <= sp_n;
            menu_active   <= (state_n == MENU);
            cursor_row    <= cursor_n;
            cursor_blink  <= blink_n;
            cnt           <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        sound_n  = sound_choice;
        theme_n  = theme_choice;
        hearts_n = hearts_choice;
        cursor_n = cursor_row;
        gs_n     = game_started;
        sp_n     = 1'b0;
        cnt_n    = cnt;
        blink_n  = cursor_blink;

        unique case (state)
            MENU: begin
                priority case (1'b1)
                    press[4]: begin
                        unique case (cursor_row)
                            2'd0: sound_n = ~sound_choice;
                            2'd1: theme_n = ~theme_choice;
                            2'd2: hearts_n = (hearts_choice >= H_MAX) ?
                                             H_MIN : hearts_choice + 3'd1;
                            default: state_n = START_WAIT;
                        endcase
                    end
                    press[3]: cursor_n = cursor_row - 2'd1;
                    press[2]: cursor_n = cursor_row + 2'd1;
                    press[1], press[0]: begin
                        unique case (cursor_row)
                            2'd0: sound_n = ~sound_choice;
                            2'd1: theme_n = ~theme_choice;
                            2'd2: begin
                                if (press[1] && hearts_choice > H_MIN)
                                    hearts_n = hearts_choice - 3'd1;
                                else if (press[0] && hearts_choice < H_MAX)
                                    hearts_n = hearts_choice + 3'd1;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            START_WAIT: begin
                if (!btn_enter) begin
                    state_n = GAME;
                    sp_n    = 1'b1;
                    gs_n    = 1'b1;
                end
            end
            GAME: begin
                if (game_over) begin
                    state_n = OVER_WAIT;
                    gs_n    = 1'b0;
                end
            end
            default: begin
                if (btn == 5'd0) begin
                    state_n  = MENU;
                    cursor_n = 2'd3;
                end
            end
        endcase

        // Moves and menu entry restart the blink with the cursor visible
        if (state_n == MENU) begin
            if (state != MENU || cursor_n != cursor_row) begin
                cnt_n   = '0;
                blink_n = 1'b1;
            end else if (startOfFrame) begin
                if (cnt == B_LAST) begin
                    cnt_n   = '0;
                    blink_n = ~cursor_blink;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        end else begin
            cnt_n   = '0;
            blink_n = 1'b0;
        end
    end

endmodule
